// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package rr_lock_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } arb_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_onehot_pick.sv
// Rotate eligible vector by ptr, pick the lowest set bit, un-rotate to a one-hot and index.
module rr_onehot_pick
    import rr_lock_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]                   elig_i,
    input  logic [clog2_min1(N_REQ)-1:0]       ptr_i,
    output logic [N_REQ-1:0]                   onehot_o,
    output logic [clog2_min1(N_REQ)-1:0]       idx_o,
    output logic                               valid_o
);

    localparam int unsigned IDX_W = clog2_min1(N_REQ);
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_REQ);

    logic [IDX_W:0]     ptr_ext;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   pos;
    logic [IDX_W:0]     sum;
    logic               hit;

    assign ptr_ext = {1'b0, ptr_i};
    // Bit k of rot is requester (ptr+k) mod N_REQ; shifts by N_REQ yield zero when ptr is 0.
    assign rot = (elig_i >> ptr_i) | (elig_i << (N_EXT - ptr_ext));

    always_comb begin
        pos = '0;
        hit = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!hit && rot[k]) begin
                hit = 1'b1;
                pos = IDX_W'(k);
            end
        end
        sum = {1'b0, pos} + ptr_ext;
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        idx_o    = sum[IDX_W-1:0];
        onehot_o = hit ? (N_REQ'(1) << idx_o) : '0;
        valid_o  = hit;
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin single-owner lock arbiter with post-release gap.
// Optional hold timeout with requester masking: define RR_LOCK_ARBITER_TIMEOUT_EN.
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned RESET_PTR  = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_cg,
    input  logic [N_REQ-1:0]                 i_req,
    output logic [N_REQ-1:0]                 o_gnt,
    output logic [clog2_min1(N_REQ)-1:0]     o_gntIdx,
    output logic                             o_busy,
    output logic                             o_timeout
);

    localparam int unsigned IDX_W    = clog2_min1(N_REQ);
    localparam int unsigned GAP_W    = clog2_min1(GAP_CYCLES);
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    if (N_REQ < 2 || N_REQ > 32 || RESET_PTR >= N_REQ || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_lock_arbiter: illegal parameter combination");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               busy_q, busy_d;
    logic               to_q, to_d;

    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               hold_expired;
    logic               revoke;

    rr_onehot_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .elig_i   (elig),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_vld)
    );

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    localparam int unsigned HOLD_W = clog2_min1(MAX_HOLD + 1);

    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]   mask_q, mask_d;

    assign elig         = i_req & ~mask_q;
    assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        hold_d = hold_q;
        // A requester stays masked until it is seen low at least once.
        mask_d = mask_q & i_req;
        if (state_q == ST_IDLE && pick_vld) begin
            hold_d = HOLD_W'(1);
        end else if (state_q == ST_GRANT) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        if (revoke) begin
            mask_d = mask_d | gnt_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q <= '0;
            mask_q <= '0;
        end else if (i_cg) begin
            hold_q <= hold_d;
            mask_q <= mask_d;
        end
    end
`else
    assign elig         = i_req;
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        gap_d   = gap_q;
        revoke  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                end
            end
            ST_GRANT: begin
                // A voluntary release in the expiry cycle wins over the timeout.
                if (!i_req[idx_q] || hold_expired) begin
                    revoke = i_req[idx_q];
                    gnt_d  = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP_LOAD);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        to_d   = revoke;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(RESET_PTR);
            idx_q   <= '0;
            gnt_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else if (i_cg) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gntIdx  = idx_q;
    assign o_busy    = busy_q;
    assign o_timeout = to_q;

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Round-robin lock arbiter that shares one single-owner resource (bus port, SRAM port, config register file) between `N_REQ` requesters. A requester holds `i_req` high for as long as it owns the resource. Grant is one-hot, registered and held until the owner drops its request, or until an optional hold timeout revokes it. The block sits between requester front-ends and the shared datapath's select/enable inputs.

## Interface
- `N_REQ`, 4, `int unsigned`: number of requesters; legal range 2..32.
- `GAP_CYCLES`, 1, `int unsigned`: idle cycles inserted after each release before the next grant; 0 allows back-to-back grants.
- `MAX_HOLD`, 16, `int unsigned`: maximum cycles of continuous ownership, used only when `RR_LOCK_ARBITER_TIMEOUT_EN` is defined; must be ≥1.
- `RESET_PTR`, 0, `int unsigned`: requester index with highest priority after reset; must be < `N_REQ`.
- `i_clk`  input  1  clock; all logic on the rising edge.
- `i_rst`  input  1  reset. Synchronous and active-high. Overrides `i_cg`.
- `i_cg`  input  1  clock-gate enable. When low, all state is frozen and outputs hold their values.
- `i_req`  input  N_REQ  per-requester request/hold.
- `o_gnt`  output  N_REQ  one-hot grant, or all-zero.
- `o_gntIdx`  output  $clog2(N_REQ)  index of the current owner; holds its last value when there is no owner.
- `o_busy`  output  1  high in GRANT or GAP.
- `o_timeout`  output  1  single-cycle pulse when a grant is revoked by timeout.

Clock `i_clk`, one clock domain. Reset `i_rst`, synchronous, active-high.

## Operation
- **States** (enum in the package): IDLE, GRANT, GAP.
- **IDLE**
  - If any `i_req` bit is eligible, pick the first set bit searching upward from `ptr` with wrap.
  - Go to GRANT and set `o_gnt`/`o_gntIdx` to the winner.
  - Set `ptr` = winner+1 mod `N_REQ`. Wrap happens at `N_REQ-1`→0, including non-power-of-two `N_REQ`.
- **GRANT**
  - The owner's `i_req` low → clear `o_gnt`. Go to GAP if `GAP_CYCLES`>0, else to IDLE.
  - Other requesters' bits are ignored while a grant is held; there is no preemption.
- **GAP**
  - A down-counter loaded with `GAP_CYCLES-1`.
  - Go to IDLE when the counter reaches 0.
- **Eligible:** `i_req` bit high and not masked. The mask is used only with the timeout feature.
- **Simultaneous events**
  - Release and a new request in the same cycle: the new request is arbitrated only once the FSM is in IDLE.
  - With `GAP_CYCLES`=0, IDLE is occupied for exactly one cycle between owners.
- **Reset values:** `o_gnt`=0, `o_gntIdx`=0, `o_busy`=0, `o_timeout`=0, state IDLE, `ptr`=`RESET_PTR`, mask=0.
- **Reset mid-grant:** `o_gnt` is 0 on the cycle after `i_rst` is sampled high. No timeout pulse is generated.

## Timing
- Request sampled in IDLE at edge t → `o_gnt` high after edge t (one-cycle latency).
- Owner drops `i_req` before edge t → `o_gnt` low after edge t.
- Minimum release-to-next-grant latency is `GAP_CYCLES`+1 cycles after `o_gnt` falls.
- `o_busy` equals (state≠IDLE) and is registered.
- `o_timeout` is high for exactly one cycle: the same cycle that `o_gnt` first reads 0 due to revocation.

## Configuration
- **`RR_LOCK_ARBITER_TIMEOUT_EN` defined**
  - A hold counter counts owner cycles in GRANT.
  - At `MAX_HOLD` cycles of continuous grant: revoke (`o_gnt`←0), pulse `o_timeout`, set the owner's mask bit, take the normal GAP/IDLE path.
  - A mask bit clears when the corresponding `i_req` is sampled low. A timed-out requester must therefore drop its request before it can win again.
- **Undefined**
  - No counter and no mask.
  - `o_timeout` is tied to 0.
  - Grants are held indefinitely.
  - `MAX_HOLD` is unused.

## Structure
- **Package `rr_lock_arbiter_pkg`:**
  - FSM state typedef.
  - Function returning the width of `$clog2` clamped to ≥1.
- **Sub-module `rr_onehot_pick`:** combinational rotate-by-`ptr`, priority-pick and un-rotate. Inputs are the eligible vector and `ptr`; outputs are the one-hot result and its index. It is reusable by other arbiters.
- **Top level:** holds the FSM, `ptr`, GAP counter, hold counter and mask.

## Test plan
- **Basic grant and release** (`N_REQ`=4, `GAP_CYCLES`=1, reset): `i_req`=4'b0100 → `o_gnt`=4'b0100 next cycle and `o_gntIdx`=2. Drop req → `o_gnt`=0. One GAP cycle, then IDLE.
- **Round-robin order:** `i_req`=4'b1111 held, each owner releasing after 3 cycles → grant order 0,1,2,3,0. Wrap from 3 to 0 observed.
- **Back-to-back:** `GAP_CYCLES`=0 with req 0 and 1 both pending → owner 0 releases, one IDLE cycle, then `o_gnt`=4'b0010.
- **Timeout** (macro defined, `MAX_HOLD`=4, req0 held forever):
  - `o_gnt[0]` high for exactly 4 cycles.
  - `o_timeout` pulses once.
  - With req1 also high, req1 is granted next.
  - Req0 is not re-granted until it toggles low→high.
- **Reset mid-grant:** `i_rst` asserted in GRANT → all outputs 0 next cycle, `ptr`=`RESET_PTR`. Arbitration after reset starts from `RESET_PTR`.
- **Clock gate:** `i_cg`=0 for 5 cycles during GRANT with the owner's req dropped → `o_gnt` unchanged. Release is taken on the first cycle `i_cg`=1.
